// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_pkg
//  Description : Shared definitions for the store write buffer: store size
//                encodings and the drain state machine state type.
//  Revision    : 1.0  initial release
// ============================================================================
package store_pkg;

    // Store size encodings as presented on st_size. 2'b11 is handled as a
    // word store wherever sizes are decoded.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Drain state machine: IDLE waits for a queued entry, REQ holds a write
    // on the memory port until it is acknowledged.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_align
//  Description : Combinational byte-lane alignment of a store. Replicates the
//                right-justified store data across the lanes it may occupy
//                and produces the matching byte enables.
//  Ports       : addr_lo    - low two bits of the store byte address
//                size       - store size (byte / half / word, 11 = word)
//                data       - right-justified store data
//                wdata      - lane-aligned write data
//                be         - byte enables, bit i covers wdata[8i+7:8i]
//                misaligned - store violates natural alignment
//                             (only with STORE_MISALIGN_TRAP_EN)
//  Config      : STORE_MISALIGN_TRAP_EN adds the misaligned output.
//  Revision    : 1.0  initial release
// ============================================================================
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    always_comb begin
        wdata = data;
        be    = 4'b1111;
        case (size)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                // Only addr_lo[1] selects the half; addr_lo[0] is ignored.
                wdata = {2{data[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                // Word (and 11): data passes through to the aligned word.
                wdata = data;
                be    = 4'b1111;
            end
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    // size[1] set covers both the word encoding and the 11 alias.
    assign misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                        (size[1] && (addr_lo != 2'b00));
`endif

endmodule
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_write_buffer
//  Description : Store-side write buffer. Accepts stores from the datapath,
//                aligns them onto byte lanes, queues them in a DEPTH-entry
//                FIFO and drains them to data memory over req/ack.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                st_valid/st_ready     - store request handshake
//                st_addr/st_data/st_size - store address, data, size
//                mem_req/mem_ack       - memory write handshake
//                mem_addr/mem_wdata/mem_be - word address, lane data, enables
//                empty                 - nothing queued or in flight
//                misalign_err          - pulse on a dropped misaligned store
//                                        (only with STORE_MISALIGN_TRAP_EN)
//  Config      : STORE_MISALIGN_TRAP_EN drops misaligned stores and reports
//                them on misalign_err; otherwise low address bits are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module store_write_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        empty
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_1 = c_ptr_w'(1);

    // FIFO storage: word address, lane data, byte enables.
    logic [29:0]        r_fifo_addr [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [3:0]         r_fifo_be   [DEPTH];

    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    drain_state_t       r_state;
    drain_state_t       w_state_next;

    logic [31:0]        w_al_wdata;
    logic [3:0]         w_al_be;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic               w_load_from_push;
    logic [c_ptr_w-1:0] w_load_idx;
    logic [29:0]        w_head_addr;
    logic [31:0]        w_head_data;
    logic [3:0]         w_head_be;

    assign st_ready = !reset && (r_count != c_full);
    assign w_accept = st_valid && st_ready;
    assign empty    = (r_count == '0);
    assign mem_req  = (r_state == REQ);

`ifdef STORE_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign_err;

    store_lane_align u_align (
        .addr_lo    (st_addr[1:0]),
        .size       (st_size),
        .data       (st_data),
        .wdata      (w_al_wdata),
        .be         (w_al_be),
        .misaligned (w_misaligned)
    );

    // Misaligned stores complete the handshake but never enter the FIFO.
    assign w_push       = w_accept && !w_misaligned;
    assign misalign_err = r_misalign_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= w_accept && w_misaligned;
        end
    end
`else
    store_lane_align u_align (
        .addr_lo (st_addr[1:0]),
        .size    (st_size),
        .data    (st_data),
        .wdata   (w_al_wdata),
        .be      (w_al_be)
    );

    assign w_push = w_accept;
`endif

    // ------------------------------------------------------------------------
    // Drain FSM: next state and control.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_pop            = 1'b0;
        w_load           = 1'b0;
        w_load_from_push = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_load       = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_pop = 1'b1;
                    if ((r_count > c_one) || w_push) begin
                        // With only the acked entry queued, the next head is
                        // the store being pushed this very cycle.
                        w_load           = 1'b1;
                        w_load_from_push = (r_count == c_one);
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // In REQ the entry at r_rd_ptr is the one being retired, so the next
    // head sits one slot further on.
    assign w_load_idx = (r_state == REQ) ? (r_rd_ptr + c_ptr_1) : r_rd_ptr;

    always_comb begin
        if (w_load_from_push) begin
            w_head_addr = st_addr[31:2];
            w_head_data = w_al_wdata;
            w_head_be   = w_al_be;
        end else begin
            w_head_addr = r_fifo_addr[w_load_idx];
            w_head_data = r_fifo_data[w_load_idx];
            w_head_be   = r_fifo_be[w_load_idx];
        end
    end

    // ------------------------------------------------------------------------
    // State, pointers, count and memory-side output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                mem_addr  <= {w_head_addr, 2'b00};
                mem_wdata <= w_head_data;
                mem_be    <= w_head_be;
            end
        end
    end

    // FIFO payload needs no reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= st_addr[31:2];
            r_fifo_data[r_wr_ptr] <= w_al_wdata;
            r_fifo_be[r_wr_ptr]   <= w_al_be;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_write_buffer
//  Description : Directed self-checking bench for store_write_buffer
//                (DEPTH = 4). Expected values are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_store_write_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;
`ifdef STORE_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int n_checks;
    int n_errors;

    store_write_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .empty     (empty)
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store presented for exactly one edge (caller ensures st_ready).
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        tick();
        st_valid = 1'b0;
    endtask

    // Wait (bounded) for a request, check its contents, then ack it once.
    task automatic drain_one(input string tag, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"},   {31'd0, mem_req}, 32'd1);
        check({tag, "_addr"},  mem_addr,  a);
        check({tag, "_wdata"}, mem_wdata, d);
        check({tag, "_be"},    {28'd0, mem_be}, {28'd0, be});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a [4];
        logic [31:0] exp_d [4];
        logic [3:0]  exp_b [4];

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        mem_ack  = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_ready", {31'd0, st_ready}, 32'd0);
        check("rst_req",   {31'd0, mem_req},  32'd0);
        check("rst_addr",  mem_addr,  32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_be",    {28'd0, mem_be}, 32'd0);
        check("rst_empty", {31'd0, empty},  32'd1);
`ifdef STORE_MISALIGN_TRAP_EN
        check("rst_mis",   {31'd0, misalign_err}, 32'd0);
`endif
        reset = 1'b0;
        tick();
        check("idle_ready", {31'd0, st_ready}, 32'd1);

        // ---------------- byte store and latency ----------------
        do_store(32'h0000_0103, 32'h0000_00AB, 2'b00);
        check("byte_e_empty", {31'd0, empty},   32'd0);
        check("byte_e_req",   {31'd0, mem_req}, 32'd0);
        tick();
        check("byte_req",   {31'd0, mem_req}, 32'd1);
        check("byte_addr",  mem_addr,  32'h0000_0100);
        check("byte_wdata", mem_wdata, 32'hABAB_ABAB);
        check("byte_be",    {28'd0, mem_be}, 32'h8);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("byte_done_req",   {31'd0, mem_req}, 32'd0);
        check("byte_done_empty", {31'd0, empty},   32'd1);

        // ---------------- half and word stores ----------------
        do_store(32'h0000_0022, 32'h0000_1234, 2'b01);
        drain_one("half", 32'h0000_0020, 32'h1234_1234, 4'b1100);
        do_store(32'h0000_0040, 32'hDEAD_BEEF, 2'b10);
        drain_one("word", 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111);
        check("word_empty", {31'd0, empty}, 32'd1);

        // ---------------- fill to full, no bypass, order ----------------
        do_store(32'h0000_0200, 32'h1111_0001, 2'b10);
        do_store(32'h0000_0204, 32'h2222_0002, 2'b10);
        do_store(32'h0000_0208, 32'h3333_0003, 2'b10);
        do_store(32'h0000_020C, 32'h4444_0004, 2'b10);
        check("full_ready", {31'd0, st_ready}, 32'd0);
        check("full_req",   {31'd0, mem_req},  32'd1);
        check("full_head",  mem_addr, 32'h0000_0200);
        st_valid = 1'b1;
        st_addr  = 32'h0000_0210;
        st_data  = 32'h5555_0005;
        st_size  = 2'b10;
        tick();
        check("full_hold_ready", {31'd0, st_ready}, 32'd0);
        check("full_hold_head",  mem_addr, 32'h0000_0200);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("pop_ready", {31'd0, st_ready}, 32'd1);
        check("pop_req",   {31'd0, mem_req},  32'd1);
        tick();
        st_valid = 1'b0;
        check("refill_ready", {31'd0, st_ready}, 32'd0);
        drain_one("fill2", 32'h0000_0204, 32'h2222_0002, 4'b1111);
        drain_one("fill3", 32'h0000_0208, 32'h3333_0003, 4'b1111);
        drain_one("fill4", 32'h0000_020C, 32'h4444_0004, 4'b1111);
        drain_one("fill5", 32'h0000_0210, 32'h5555_0005, 4'b1111);
        check("fill_end_req",   {31'd0, mem_req}, 32'd0);
        check("fill_end_empty", {31'd0, empty},   32'd1);

        // ---------------- continuous ack, 4 queued ----------------
        exp_a[0] = 32'h0000_0300; exp_d[0] = 32'h1111_1111; exp_b[0] = 4'b0001;
        exp_a[1] = 32'h0000_0300; exp_d[1] = 32'h2222_2222; exp_b[1] = 4'b0010;
        exp_a[2] = 32'h0000_0300; exp_d[2] = 32'h3344_3344; exp_b[2] = 4'b1100;
        exp_a[3] = 32'h0000_0304; exp_d[3] = 32'hCAFE_F00D; exp_b[3] = 4'b1111;
        do_store(32'h0000_0300, 32'h0000_0011, 2'b00);
        do_store(32'h0000_0301, 32'h0000_0022, 2'b00);
        do_store(32'h0000_0302, 32'h0000_3344, 2'b01);
        do_store(32'h0000_0304, 32'hCAFE_F00D, 2'b11);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst%0d_req", i),   {31'd0, mem_req}, 32'd1);
            check($sformatf("burst%0d_addr", i),  mem_addr,  exp_a[i]);
            check($sformatf("burst%0d_wdata", i), mem_wdata, exp_d[i]);
            check($sformatf("burst%0d_be", i),    {28'd0, mem_be}, {28'd0, exp_b[i]});
            tick();
        end
        mem_ack = 1'b0;
        check("burst_end_req",   {31'd0, mem_req}, 32'd0);
        check("burst_end_empty", {31'd0, empty},   32'd1);

        // ---------------- reset mid-handshake ----------------
        do_store(32'h0000_0400, 32'h0000_0001, 2'b10);
        do_store(32'h0000_0404, 32'h0000_0002, 2'b10);
        do_store(32'h0000_0408, 32'h0000_0003, 2'b10);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_req",   {31'd0, mem_req},  32'd0);
        check("mid_rst_empty", {31'd0, empty},    32'd1);
        check("mid_rst_ready", {31'd0, st_ready}, 32'd0);
        check("mid_rst_addr",  mem_addr, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst%0d_req", i), {31'd0, mem_req}, 32'd0);
        end
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        // ---------------- misaligned word store ----------------
        do_store(32'h0000_0041, 32'h5566_7788, 2'b10);
`ifdef STORE_MISALIGN_TRAP_EN
        check("mis_pulse", {31'd0, misalign_err}, 32'd1);
        check("mis_empty", {31'd0, empty},        32'd1);
        tick();
        check("mis_clear", {31'd0, misalign_err}, 32'd0);
        check("mis_noreq", {31'd0, mem_req},      32'd0);
        tick();
        check("mis_noreq2", {31'd0, mem_req}, 32'd0);
        check("mis_empty2", {31'd0, empty},   32'd1);
`else
        drain_one("mis", 32'h0000_0040, 32'h5566_7788, 4'b1111);
        check("mis_empty", {31'd0, empty}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_write_buffer.md
# store_write_buffer

Store-side memory write buffer for the multicycle CPU, the write-direction counterpart of the memory data register on the load path. It accepts store requests (address, data, size) from the datapath, aligns the data onto byte lanes with byte enables, queues them in a small FIFO, and drains them to data memory over a req/ack handshake. The CPU therefore continues after a store without waiting for memory.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept; a store transfers on st_valid && st_ready at a rising edge.
- st_addr  in  32  byte address of the store.
- st_data  in  32  store data, right-justified.
- st_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_req  out  1  write request to memory.
- mem_ack  in  1  memory has taken the current write (single-cycle pulse).
- mem_addr  out  32  word address: {st_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- empty  out  1  no entries queued or in flight.
- misalign_err  out  1  one-cycle pulse on a dropped misaligned store (present only with the macro).

## Operation
- Alignment of an accepted store:
  - Byte: st_data[7:0] is replicated on all four lanes; mem_be = 1 << st_addr[1:0].
  - Half: st_data[15:0] is replicated on both halves; mem_be = st_addr[1] ? 1100 : 0011.
  - Word: st_data is passed through; mem_be = 1111.
- FIFO: holds {mem_addr, mem_wdata, mem_be} and a count of 0..DEPTH.
  - st_ready = !reset && count != DEPTH.
  - A full FIFO does not accept a new store in the same cycle as a pop; there is no bypass.
- The head entry stays in the FIFO until it is acked, so count includes the in-flight write.
- empty = (count == 0).
- Drain FSM, states IDLE and REQ:
  - IDLE: if count != 0, load the head into the mem_* output registers and go to REQ.
  - REQ: mem_req = 1; mem_addr, mem_wdata and mem_be stay stable until mem_ack.
  - On mem_ack: pop the head. If count after the pop is nonzero (including a same-cycle push), load the new head and stay in REQ with mem_req held high. Otherwise go to IDLE with mem_req = 0.
- mem_ack while in IDLE is ignored.
- Push and pop in the same cycle leave count unchanged; the read and write pointers wrap modulo DEPTH.
- Reset (at any time, including mid-handshake): count and pointers go to 0, the FSM goes to IDLE, and the pending write is abandoned.
- Reset values of outputs: mem_req 0, mem_addr/mem_wdata/mem_be 0, empty 1, misalign_err 0, st_ready 0 while reset is high.

## Timing
- Store accepted at edge E into an empty buffer with the FSM in IDLE: count = 1 after E; mem_req is high after edge E+1. Latency is 2 cycles from acceptance to request.
- Back-to-back drain: each mem_ack pulse retires one entry per cycle, and mem_req never drops while entries remain.
- After the ack of the last entry, empty is high from the following cycle.

## Configuration
- STORE_MISALIGN_TRAP_EN defined:
  - Misaligned stores are accepted but not enqueued: half with st_addr[0] = 1, or word with st_addr[1:0] != 0.
  - misalign_err is high for the cycle after the accepting edge.
- STORE_MISALIGN_TRAP_EN not defined:
  - Low address bits are ignored. A half store uses only st_addr[1]; a word store is forced to the aligned word.
  - All stores are enqueued.
  - The misalign_err port is absent.

## Structure
- Shared package store_pkg holds the size encodings SZ_BYTE, SZ_HALF and SZ_WORD, and the FSM state typedef (IDLE, REQ).
- One combinational sub-module, store_lane_align, maps (addr[1:0], size, data) to (wdata, be), plus the misaligned flag when the macro is defined.
- FIFO storage and the drain FSM live in the top module.

## Test plan
- Byte store: addr 0x103, data 0xAB → mem_addr 0x100, mem_wdata 0xABABABAB, mem_be 1000, mem_req high 2 cycles after acceptance.
- Half store: addr 0x22, data 0x1234 → mem_wdata 0x12341234, mem_be 1100; word store to 0x40 → mem_be 1111.
- Fill: push 5 stores with mem_ack held low and DEPTH = 4 → st_ready low after the 4th; one ack → st_ready high next cycle; order preserved at the memory side.
- Continuous ack with 4 queued → mem_req high for 4 consecutive entries, then low; empty high afterwards.
- Reset asserted while mem_req is high with 3 entries queued → mem_req 0 and empty 1 after the reset edge; no further writes issued.
- Macro defined: word store to 0x41 → misalign_err pulses once, no mem_req. Macro undefined: the same store writes mem_addr 0x40 with be 1111.
